ones_count_arbiter: RTL and testbench
=====================================

// Module: ones_count_arbiter
// PURPOSE
//  Shares one bit-counting datapath among N_REQ requesters.
//  Arbitrates round-robin and loads the winner's word into the datapath.
//  Drives shift until the datapath reports done, then returns the count to the winner.
//  Sits between the requesters and the datapath's load_A/shift/done/result interface.
// PARAMETERS
//  N_REQ   4                     number of requesters (>=2)
//  DATA_W  8                     width of word to count
//  CNT_W   $clog2(DATA_W+1)      width of the ones count
// PORTS
//  clock       in   1             single clock, rising edge
//  reset       in   1             asynchronous, active-high
//  req         in   N_REQ         req[i]=1: requester i wants a count; held until done[i]
//  req_data    in   N_REQ*DATA_W  word i at [i*DATA_W +: DATA_W]; stable while req[i]
//  grant       out  N_REQ         one-hot, registered; current owner of the datapath
//  done        out  N_REQ         one-cycle pulse to the owner; result_out valid that cycle
//  result_out  out  CNT_W         registered count, holds until next capture
//  busy        out  1             1 whenever state != S_IDLE
//  err         out  1             watchdog abort pulse (see CONFIGURATION)
//  dp_load     out  1             datapath: load dp_data this cycle
//  dp_data     out  DATA_W        req_data of granted index; 0 when grant==0
//  dp_shift    out  1             datapath: shift one bit this cycle
//  dp_done     in   1             datapath: register is all zero
//  dp_result   in   CNT_W         datapath running count
// BEHAVIOUR
//  Reset (async, any state): state=S_IDLE.
//   Outputs grant, done, result_out, busy, err, dp_load and dp_shift all go to 0.
//   ptr=N_REQ-1, so requester 0 wins first.
//  FSM states and transitions:
//   S_IDLE: if |req, choose first i with req[i], searching ptr+1, ptr+2, ... (mod N_REQ).
//           Register idx=i, set grant[i], go to S_LOAD. Otherwise stay in S_IDLE.
//   S_LOAD: dp_load=1 for exactly 1 cycle, then go to S_SHIFT.
//   S_SHIFT: dp_shift = ~dp_done. When dp_done=1, go to S_DONE.
//   S_DONE: result_out<=dp_result, done[idx]=1 for one cycle, ptr<=idx, go to S_RELEASE.
//   S_RELEASE: grant held. Once req[idx]=0, clear grant and go to S_IDLE.
//  Latency: req seen at edge k -> grant at k. dp_load during the cycle after k.
//   Shifting then takes N cycles.
//   For a word whose highest set bit is position h, N = h+1.
//  Boundary conditions:
//   - Word == 0: dp_done high right after load, so zero shift cycles.
//     Expected result_out = 0, done pulse 3 cycles after grant.
//   - Owner drops req before S_DONE (abort): go to S_IDLE next cycle, grant cleared,
//     no done pulse, result_out unchanged, ptr<=idx.
//   - New req[j] during a transaction: queued. It is not evaluated until S_IDLE.
//   - req[idx] still high in S_RELEASE: stay there. The same requester cannot re-win
//     without dropping req for at least 1 cycle.
//   - All requesters active: strict rotation 0,1,2,3,0...
//   - dp_load and dp_shift are never high in the same cycle.
//   - grant is always one-hot or zero.
// CONFIGURATION
//  ONES_ARB_WATCHDOG_EN defined:
//   - In S_SHIFT a counter increments each cycle.
//   - If it reaches DATA_W+1 with dp_done still 0: err=1 for one cycle,
//     result_out<={CNT_W{1'b1}}, done[idx] pulse, go to S_RELEASE.
//  ONES_ARB_WATCHDOG_EN undefined: err tied 0, no counter, S_SHIFT waits indefinitely.
// TESTING
//  1. Reset mid-S_SHIFT -> all outputs 0 within the same cycle.
//     Next req[2] alone -> grant=4'b0100.
//  2. req[0], data=8'b1011_0110 -> one dp_load, 8 dp_shift cycles.
//     Then done[0] with result_out=5.
//  3. Data 8'h00 on req[1] -> zero dp_shift cycles, result_out=0, done[1] pulse.
//  4. req=4'b1111 held/re-raised -> grant order 0,1,2,3,0.
//     Each grant pulses done exactly once.
//  5. req[3] dropped during S_SHIFT -> no done, grant 0 next cycle,
//     pending req[0] granted after.
//  6. WATCHDOG_EN, datapath model with dp_done stuck 0 -> err pulse after 9 shift cycles,
//     result_out=all ones.

Source files
------------

// File: rtl/ones_count_arbiter.sv
// ones_count_arbiter: round-robin share of one bit-counting datapath among N_REQ requesters
//   clock      : rising-edge clock
//   reset      : asynchronous active-high reset
//   req        : per-requester count request, held until its done pulse
//   req_data   : word i at [i*DATA_W +: DATA_W]
//   grant      : registered one-hot owner of the datapath
//   done       : one-cycle pulse to the owner, result_out valid that cycle
//   result_out : registered count, held until the next capture
//   busy       : FSM not idle
//   err        : watchdog abort pulse (ONES_ARB_WATCHDOG_EN), else tied 0
//   dp_load/dp_data/dp_shift/dp_done/dp_result : datapath interface
//   Optional feature macro: ONES_ARB_WATCHDOG_EN
module ones_count_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic [N_REQ-1:0]        done,
    output logic [CNT_W-1:0]        result_out,
    output logic                    busy,
    output logic                    err,
    output logic                    dp_load,
    output logic [DATA_W-1:0]       dp_data,
    output logic                    dp_shift,
    input  logic                    dp_done,
    input  logic [CNT_W-1:0]        dp_result
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE, S_RELEASE} state_t;
    state_t            state, state_d;
    logic [IW-1:0]     ptr, ptr_d, idx, idx_d, win, j;
    logic              found;
    logic [N_REQ-1:0]  grant_d, done_d, own;
    logic [CNT_W-1:0]  result_d;
`ifdef ONES_ARB_WATCHDOG_EN
    logic [CNT_W-1:0]  wd, wd_d;
    logic              err_d;
`endif
    assign own      = N_REQ'(1) << idx;
    assign busy     = state != S_IDLE;
    assign dp_load  = state == S_LOAD;
    assign dp_shift = state == S_SHIFT && !dp_done;
    // search starts just after the last owner so every requester gets a turn
    always_comb begin
        found = 1'b0;
        win   = '0;
        j     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = IW'((int'(ptr) + k) % N_REQ);
            if (!found && req[j]) begin
                found = 1'b1;
                win   = j;
            end
        end
    end
    always_comb begin
        dp_data = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) dp_data = dp_data | req_data[i*DATA_W +: DATA_W];
    end
    always_comb begin
        state_d  = state;
        grant_d  = grant;
        done_d   = '0;
        result_d = result_out;
        ptr_d    = ptr;
        idx_d    = idx;
`ifdef ONES_ARB_WATCHDOG_EN
        wd_d     = '0;
        err_d    = 1'b0;
`endif
        case (state)
            S_IDLE: if (found) begin
                idx_d   = win;
                grant_d = N_REQ'(1) << win;
                state_d = S_LOAD;
            end
            S_LOAD: if (!req[idx]) begin
                grant_d = '0;
                ptr_d   = idx;
                state_d = S_IDLE;
            end else state_d = S_SHIFT;
            S_SHIFT: begin
                // owner withdrawing mid-count aborts without a done pulse
                if (!req[idx]) begin
                    grant_d = '0;
                    ptr_d   = idx;
                    state_d = S_IDLE;
                end else if (dp_done) state_d = S_DONE;
`ifdef ONES_ARB_WATCHDOG_EN
                else if (wd == CNT_W'(DATA_W)) begin
                    err_d    = 1'b1;
                    result_d = '1;
                    done_d   = own;
                    ptr_d    = idx;
                    state_d  = S_RELEASE;
                end else wd_d = wd + 1'b1;
`endif
            end
            S_DONE: begin
                result_d = dp_result;
                done_d   = own;
                ptr_d    = idx;
                state_d  = S_RELEASE;
            end
            S_RELEASE: if (!req[idx]) begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            grant      <= '0;
            done       <= '0;
            result_out <= '0;
            ptr        <= IW'(N_REQ - 1);
            idx        <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            done       <= done_d;
            result_out <= result_d;
            ptr        <= ptr_d;
            idx        <= idx_d;
        end
    end
`ifdef ONES_ARB_WATCHDOG_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd  <= wd_d;
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ones_count_arbiter.sv
// tb_ones_count_arbiter: directed checks of ones_count_arbiter with a behavioural datapath
module tb_ones_count_arbiter;
    localparam int N = 4, W = 8, CW = 4;
    logic clock = 1'b0, reset = 1'b1, stuck = 1'b0, bad = 1'b0;
    logic [N-1:0] req = '0, grant, done;
    logic [N*W-1:0] req_data = '0;
    logic [CW-1:0] result_out, dp_result, acc = '0;
    logic busy, err, dp_load, dp_shift, dp_done;
    logic [W-1:0] dp_data, sr = '0;
    int checks = 0, errors = 0, n_load = 0, n_shift = 0, n_done = 0;

    ones_count_arbiter #(.N_REQ(N), .DATA_W(W), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .result_out(result_out), .busy(busy), .err(err),
        .dp_load(dp_load), .dp_data(dp_data), .dp_shift(dp_shift),
        .dp_done(dp_done), .dp_result(dp_result)
    );

    always #5 clock = ~clock;

    assign dp_done   = !stuck && sr == '0;
    assign dp_result = acc;
    always @(posedge clock) begin
        if (dp_load) begin
            sr  <= dp_data;
            acc <= '0;
        end else if (dp_shift) begin
            sr  <= sr >> 1;
            acc <= acc + CW'(sr[0]);
        end
    end

    always @(posedge clock) begin
        if (dp_load) n_load++;
        if (dp_shift) n_shift++;
        if (|done) n_done++;
        if ((dp_load && dp_shift) || !$onehot0(grant)) bad = 1'b1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xact(input int i, input logic [N-1:0] other, input logic [CW-1:0] exp_res, input int exp_sh);
        int cyc, l0, s0, d0;
        logic [N-1:0] g;
        g = N'(1) << i;
        l0 = n_load; s0 = n_shift; d0 = n_done;
        req = other | g;
        tick;
        chk("grant", grant, g);
        cyc = 0;
        while (done == '0 && cyc < 60) begin
            tick;
            cyc++;
        end
        chk("done_owner", done, g);
        chk("result", result_out, exp_res);
        chk("latency", cyc, 3 + exp_sh);
        chk("loads", n_load - l0, 1);
        chk("shifts", n_shift - s0, exp_sh);
        tick;
        chk("done_pulse", done, 0);
        chk("grant_hold", grant, g);
        req = other & ~g;
        tick;
        chk("release", grant, 0);
        chk("done_once", n_done - d0, 1);
    endtask

    initial begin
        int cyc, d0, s0;
        int order[5] = '{0, 1, 2, 3, 0};
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result_out, 0);
        tick; tick;
        reset = 1'b0;
        // reset while shifting
        req_data[0*W +: W] = 8'hFF;
        req = 4'b0001;
        tick; tick;
        chk("pre_rst_shift", dp_shift, 1);
        reset = 1'b1;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_shift", dp_shift, 0);
        chk("arst_load", dp_load, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_result", result_out, 0);
        req = '0;
        tick;
        reset = 1'b0;
        tick;
        req_data[2*W +: W] = 8'h03;
        xact(2, 4'b0000, 4'd2, 2);
        // popcount of 1011_0110 is 5, highest bit 7
        req_data[0*W +: W] = 8'b1011_0110;
        xact(0, 4'b0000, 4'd5, 8);
        req_data[1*W +: W] = 8'h00;
        xact(1, 4'b0000, 4'd0, 0);
        req_data[3*W +: W] = 8'h80;
        xact(3, 4'b0000, 4'd1, 8);
        // all requesting: rotation 0,1,2,3,0
        req_data = {8'h0F, 8'h07, 8'h03, 8'h01};
        for (int r = 0; r < 5; r++) xact(order[r], 4'b1111, CW'(order[r] + 1), order[r] + 1);
        // abort by requester 3 while requester 0 waits
        req_data[3*W +: W] = 8'h80;
        req = 4'b1001;
        tick;
        chk("ab_grant", grant, 4'b1000);
        tick; tick;
        chk("ab_shifting", dp_shift, 1);
        d0 = n_done;
        req = 4'b0001;
        tick;
        chk("ab_grant0", grant, 0);
        chk("ab_nodone", done, 0);
        chk("ab_result", result_out, 1);
        chk("ab_idle", busy, 0);
        tick;
        chk("ab_next", grant, 4'b0001);
        cyc = 0;
        while (done == '0 && cyc < 60) begin
            tick;
            cyc++;
        end
        chk("ab_done0", done, 4'b0001);
        chk("ab_res0", result_out, 1);
        tick;
        chk("ab_done_cnt", n_done - d0, 1);
        req = 4'b0000;
        tick;
        chk("ab_rel", grant, 0);
        // datapath that never finishes
        stuck = 1'b1;
        req_data[1*W +: W] = 8'hFF;
        req = 4'b0010;
        tick;
        chk("wd_grant", grant, 4'b0010);
        s0 = n_shift;
`ifdef ONES_ARB_WATCHDOG_EN
        cyc = 0;
        while (!err && cyc < 40) begin
            tick;
            cyc++;
        end
        chk("wd_err", err, 1);
        chk("wd_done", done, 4'b0010);
        chk("wd_result", result_out, 4'hF);
        chk("wd_shifts", n_shift - s0, 9);
        chk("wd_latency", cyc, 10);
        tick;
        chk("wd_err_pulse", err, 0);
        chk("wd_hold", grant, 4'b0010);
        req = 4'b0000;
        tick;
        chk("wd_rel", grant, 0);
`else
        repeat (15) tick;
        chk("nowd_err", err, 0);
        chk("nowd_busy", busy, 1);
        chk("nowd_shift", dp_shift, 1);
        chk("nowd_shifts", n_shift - s0, 14);
        req = 4'b0000;
        tick;
        chk("nowd_abort", grant, 0);
        chk("nowd_idle", busy, 0);
`endif
        stuck = 1'b0;
        chk("excl_onehot", bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
